imem_responder: RTL

- Instruction-memory responder that serves the fetch stage's 64-bit byte address (`imem_addr_F`) and returns a 32-bit instruction word.
- Models a word-organised instruction store with a configurable number of wait states.
- Drives a stall back to fetch while an access is outstanding.
- Includes a load port so a bench or boot loader can write the store before and during execution.

---
 rtl/imem_responder.sv | 124 ++++++++++++
 1 files changed

// File: rtl/imem_responder.sv
// rtl/imem_responder.sv - word-organised instruction store answering fetch after WAIT_STATES extra cycles
// Defining IMEM_FAULT_EN adds fault_F for misaligned or out-of-range fetch addresses.
module imem_responder #(
   parameter int N_WORDS     = 64,
   parameter int WAIT_STATES = 1,
   localparam int IW         = $clog2(N_WORDS)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [63:0]   imem_addr_F,
   output logic [31:0]   instr_F,
   output logic          instr_valid_F,
   output logic          stall_F,
`ifdef IMEM_FAULT_EN
   output logic          fault_F,
`endif
   input  logic          load_en,
   input  logic [IW-1:0] load_idx,
   input  logic [31:0]   load_data
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ACCESS = 2'd1;
   localparam logic [1:0] S_DONE   = 2'd2;
   localparam logic [3:0] WS       = 4'(WAIT_STATES);

   logic [31:0]   mem_q [N_WORDS];
   logic [1:0]    state_q, state_d;
   logic [63:0]   cur_addr_q, cur_addr_d;
   logic [3:0]    cnt_q, cnt_d;
   logic [31:0]   instr_q, instr_d;
   logic          valid_q, valid_d;
   logic          addr_match;
   logic [IW-1:0] cur_idx;

`ifdef IMEM_FAULT_EN
   logic fault_q, fault_d;
   logic access_fault;
   assign access_fault = (cur_addr_q[1:0] != 2'b00) || (cur_addr_q[63:IW+2] != '0);
   assign fault_F      = fault_q;
`endif

   assign addr_match    = (imem_addr_F == cur_addr_q);
   assign cur_idx       = cur_addr_q[IW+1:2];
   assign instr_F       = instr_q;
   assign instr_valid_F = valid_q;
   assign stall_F       = reset || !((state_q == S_DONE) && addr_match);

   always_comb begin
      state_d    = state_q;
      cur_addr_d = cur_addr_q;
      cnt_d      = cnt_q;
      instr_d    = instr_q;
      valid_d    = valid_q;
`ifdef IMEM_FAULT_EN
      fault_d    = fault_q;
`endif
      case (state_q)
         S_IDLE: begin
            cur_addr_d = imem_addr_F;
            cnt_d      = WS;
            state_d    = S_ACCESS;
            valid_d    = 1'b0;
         end
         S_ACCESS: begin
            // A new address aborts the access; its data is never shown.
            if (!addr_match) begin
               cur_addr_d = imem_addr_F;
               cnt_d      = WS;
            end else if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               state_d = S_DONE;
               valid_d = 1'b1;
               instr_d = mem_q[cur_idx];
`ifdef IMEM_FAULT_EN
               fault_d = access_fault;
               if (access_fault) instr_d = 32'h0;
`endif
            end
         end
         S_DONE: begin
            if (!addr_match) begin
               cur_addr_d = imem_addr_F;
               cnt_d      = WS;
               state_d    = S_ACCESS;
               valid_d    = 1'b0;
`ifdef IMEM_FAULT_EN
               fault_d    = 1'b0;
`endif
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         cur_addr_q <= 64'h0;
         cnt_q      <= 4'd0;
         instr_q    <= 32'h0;
         valid_q    <= 1'b0;
`ifdef IMEM_FAULT_EN
         fault_q    <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         cur_addr_q <= cur_addr_d;
         cnt_q      <= cnt_d;
         instr_q    <= instr_d;
         valid_q    <= valid_d;
`ifdef IMEM_FAULT_EN
         fault_q    <= fault_d;
`endif
      end
   end

   // Store writes ignore reset so a boot loader can fill it while reset is held.
   always_ff @(posedge clk) begin
      if (load_en) mem_q[load_idx] <= load_data;
   end

endmodule
